wb_arbiter: RTL and testbench

- Writeback stage directly upstream of the register file write port (wr_addr / wr_en / wr_data).
- Merges two independent result producers into the single write port: source A (ALU) and source B (load/memory unit). Each producer uses a valid/ready handshake.
- Each source has a one-entry holding register. Contention is resolved round-robin, and the selected result goes through a registered output stage.
- Exports a per-register pending mask so decode can stall on RAW hazards until the write has landed.

---
 rtl/wb_arbiter_if.sv | 37 +++
 rtl/wb_arbiter.sv | 163 ++++++++++++++++
 tb/tb_wb_arbiter.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus bundle.
// Purpose : groups the two producer handshakes (A = ALU, B = load unit), the
//           register-file write port and the hazard/status outputs.
// Signals : a_*/b_*   valid/ready/addr/data per producer
//           wr_*      register file write port (addr/en/data)
//           pending   per-register "write in flight" mask, idle status
// Modports: slave  = arbiter view, master = producer/consumer (bench) view.
interface wb_arbiter_if #(
  parameter int unsigned WIDTH_ADDR = 5,
  parameter int unsigned WIDTH_DATA = 32
);
  localparam int unsigned NUM_REGS = 1 << WIDTH_ADDR;

  logic                  a_valid;
  logic                  a_ready;
  logic [WIDTH_ADDR-1:0] a_addr;
  logic [WIDTH_DATA-1:0] a_data;
  logic                  b_valid;
  logic                  b_ready;
  logic [WIDTH_ADDR-1:0] b_addr;
  logic [WIDTH_DATA-1:0] b_data;
  logic [WIDTH_ADDR-1:0] wr_addr;
  logic                  wr_en;
  logic [WIDTH_DATA-1:0] wr_data;
  logic [NUM_REGS-1:0]   pending;
  logic                  idle;

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_ready, b_ready, wr_addr, wr_en, wr_data, pending, idle
  );

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  a_ready, b_ready, wr_addr, wr_en, wr_data, pending, idle
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU (A) and load unit (B) results into the single
// register file write port.
// Ports : clk, rst (async, active-high)
//         bus (wb_arbiter_if.slave): per-source valid/ready/addr/data in,
//         wr_addr/wr_en/wr_data out, pending mask and idle out.
// Each source owns a one-entry holding register; contention between the two
// holding registers is resolved round-robin and the winner is registered into
// the write stage. Writes to register 0 are dropped when ZERO_REG_WE=0 but
// still take their arbitration slot so ordering is preserved.
module wb_arbiter #(
  parameter int unsigned WIDTH_ADDR  = 5,
  parameter int unsigned WIDTH_DATA  = 32,
  parameter bit          ZERO_REG_WE = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  wb_arbiter_if.slave  bus
);
  localparam int unsigned NUM_REGS = 1 << WIDTH_ADDR;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

  logic                  hold_a_v_q,    hold_a_v_d;
  logic [WIDTH_ADDR-1:0] hold_a_addr_q, hold_a_addr_d;
  logic [WIDTH_DATA-1:0] hold_a_data_q, hold_a_data_d;
  logic                  hold_b_v_q,    hold_b_v_d;
  logic [WIDTH_ADDR-1:0] hold_b_addr_q, hold_b_addr_d;
  logic [WIDTH_DATA-1:0] hold_b_data_q, hold_b_data_d;
  src_e                  last_grant_q,  last_grant_d;
  logic                  wr_en_q,       wr_en_d;
  logic [WIDTH_ADDR-1:0] wr_addr_q,     wr_addr_d;
  logic [WIDTH_DATA-1:0] wr_data_q,     wr_data_d;

  logic                  grant_a;
  logic                  grant_b;
  logic                  a_ready_c;
  logic                  b_ready_c;
  logic                  hs_a;
  logic                  hs_b;
  logic [NUM_REGS-1:0]   pending_c;

  // True when a write to this address actually reaches the register file.
  function automatic logic writable(input logic [WIDTH_ADDR-1:0] addr);
    return ZERO_REG_WE || (addr != '0);
  endfunction

  // Round-robin arbitration over the registered holding state.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (hold_a_v_q && hold_b_v_q) begin
      grant_a = (last_grant_q == SRC_B);
      grant_b = (last_grant_q == SRC_A);
    end else begin
      grant_a = hold_a_v_q;
      grant_b = hold_b_v_q;
    end
  end

  // Ready depends only on registered state (and reset), never on valid.
  always_comb begin
    a_ready_c = !rst && (!hold_a_v_q || grant_a);
    b_ready_c = !rst && (!hold_b_v_q || grant_b);
    hs_a      = bus.a_valid && a_ready_c;
    hs_b      = bus.b_valid && b_ready_c;
  end

  // Next-state for holding registers, rr pointer and write stage.
  always_comb begin
    hold_a_v_d    = hold_a_v_q;
    hold_a_addr_d = hold_a_addr_q;
    hold_a_data_d = hold_a_data_q;
    hold_b_v_d    = hold_b_v_q;
    hold_b_addr_d = hold_b_addr_q;
    hold_b_data_d = hold_b_data_q;
    last_grant_d  = last_grant_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;

    if (hs_a) begin
      hold_a_v_d    = 1'b1;
      hold_a_addr_d = bus.a_addr;
      hold_a_data_d = bus.a_data;
    end else if (grant_a) begin
      hold_a_v_d = 1'b0;
    end

    if (hs_b) begin
      hold_b_v_d    = 1'b1;
      hold_b_addr_d = bus.b_addr;
      hold_b_data_d = bus.b_data;
    end else if (grant_b) begin
      hold_b_v_d = 1'b0;
    end

    if (grant_a) begin
      last_grant_d = SRC_A;
      wr_addr_d    = hold_a_addr_q;
      wr_data_d    = hold_a_data_q;
      wr_en_d      = writable(hold_a_addr_q);
    end else if (grant_b) begin
      last_grant_d = SRC_B;
      wr_addr_d    = hold_b_addr_q;
      wr_data_d    = hold_b_data_q;
      wr_en_d      = writable(hold_b_addr_q);
    end
  end

  // State registers; reset leaves the pointer on B so A wins first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_a_v_q    <= 1'b0;
      hold_a_addr_q <= '0;
      hold_a_data_q <= '0;
      hold_b_v_q    <= 1'b0;
      hold_b_addr_q <= '0;
      hold_b_data_q <= '0;
      last_grant_q  <= SRC_B;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
    end else begin
      hold_a_v_q    <= hold_a_v_d;
      hold_a_addr_q <= hold_a_addr_d;
      hold_a_data_q <= hold_a_data_d;
      hold_b_v_q    <= hold_b_v_d;
      hold_b_addr_q <= hold_b_addr_d;
      hold_b_data_q <= hold_b_data_d;
      last_grant_q  <= last_grant_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
    end
  end

  // In-flight mask: both holding entries plus the write stage.
  always_comb begin
    pending_c = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if ((hold_a_v_q && (hold_a_addr_q == WIDTH_ADDR'(i))) ||
          (hold_b_v_q && (hold_b_addr_q == WIDTH_ADDR'(i))) ||
          (wr_en_q    && (wr_addr_q     == WIDTH_ADDR'(i)))) begin
        pending_c[i] = 1'b1;
      end
    end
    // Register 0 is never written, so it never blocks decode.
    if (!ZERO_REG_WE) begin
      pending_c[0] = 1'b0;
    end
  end

  assign bus.a_ready = a_ready_c;
  assign bus.b_ready = b_ready_c;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.pending = pending_c;
  assign bus.idle    = !hold_a_v_q && !hold_b_v_q && !wr_en_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: per-cycle vector table plus a hand-written
// continuous-traffic sequence. A second instance with ZERO_REG_WE=1 follows
// the same inputs so the register-0 behaviour of both settings is compared.
module tb_wb_arbiter;
  localparam int unsigned WA = 5;
  localparam int unsigned WD = 32;

  logic clk;
  logic rst;

  wb_arbiter_if #(.WIDTH_ADDR(WA), .WIDTH_DATA(WD)) bus0 ();
  wb_arbiter_if #(.WIDTH_ADDR(WA), .WIDTH_DATA(WD)) bus1 ();

  wb_arbiter #(.WIDTH_ADDR(WA), .WIDTH_DATA(WD), .ZERO_REG_WE(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  wb_arbiter #(.WIDTH_ADDR(WA), .WIDTH_DATA(WD), .ZERO_REG_WE(1'b1)) dut_z1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  assign bus1.a_valid = bus0.a_valid;
  assign bus1.a_addr  = bus0.a_addr;
  assign bus1.a_data  = bus0.a_data;
  assign bus1.b_valid = bus0.b_valid;
  assign bus1.b_addr  = bus0.b_addr;
  assign bus1.b_data  = bus0.b_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          av;
    logic [WA-1:0] aa;
    logic [WD-1:0] ad;
    logic          bv;
    logic [WA-1:0] ba;
    logic [WD-1:0] bd;
    logic          ar;
    logic          br;
    logic          we;
    logic [WA-1:0] wa;
    logic [WD-1:0] wd;
    logic [31:0]   pend;
    logic          idle;
    logic          we1;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   row      = 0;

  function automatic vec_t v(
    input logic rst_v,
    input logic av, input logic [WA-1:0] aa, input logic [WD-1:0] ad,
    input logic bv, input logic [WA-1:0] ba, input logic [WD-1:0] bd,
    input logic ar, input logic br,
    input logic we, input logic [WA-1:0] wa, input logic [WD-1:0] wd,
    input logic [31:0] pend, input logic idle, input logic we1);
    vec_t r;
    r.rst = rst_v; r.av = av; r.aa = aa; r.ad = ad;
    r.bv = bv; r.ba = ba; r.bd = bd;
    r.ar = ar; r.br = br; r.we = we; r.wa = wa; r.wd = wd;
    r.pend = pend; r.idle = idle; r.we1 = we1;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (row %0d, t=%0t): got %h, expected %h", name, row, $time, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus0.a_valid = 1'b0; bus0.a_addr = '0; bus0.a_data = '0;
    bus0.b_valid = 1'b0; bus0.b_addr = '0; bus0.b_data = '0;
  endtask

  initial begin
    int ia, ib, nwr, first_c, last_c;
    logic hs_a, hs_b;
    logic [WA-1:0] ea;
    logic [WD-1:0] ed;

    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);

    // rst av aa ad bv ba bd | ar br we wa wd pend idle we1
    vecs.push_back(v(1, 0,0,0, 0,0,0, 0,0, 0,0,0, 32'h0,1, 0));
    // single A write to r5
    vecs.push_back(v(0, 1,5,32'hDEADBEEF, 0,0,0, 1,1, 0,0,0, 32'h0,1, 0));
    vecs.push_back(v(0, 0,0,0, 0,0,0, 1,1, 0,0,0, 32'h20,0, 0));
    vecs.push_back(v(0, 0,0,0, 0,0,0, 1,1, 1,5,32'hDEADBEEF, 32'h20,0, 1));
    vecs.push_back(v(0, 0,0,0, 0,0,0, 1,1, 0,5,32'hDEADBEEF, 32'h0,1, 0));
    // simultaneous A(r3) / B(r4) after reset: A first, B stalls a cycle
    vecs.push_back(v(1, 0,0,0, 0,0,0, 0,0, 0,0,0, 32'h0,1, 0));
    vecs.push_back(v(0, 1,3,32'h11, 1,4,32'h22, 1,1, 0,0,0, 32'h0,1, 0));
    vecs.push_back(v(0, 0,0,0, 0,0,0, 1,0, 0,0,0, 32'h18,0, 0));
    vecs.push_back(v(0, 0,0,0, 0,0,0, 1,1, 1,3,32'h11, 32'h18,0, 1));
    vecs.push_back(v(0, 0,0,0, 0,0,0, 1,1, 1,4,32'h22, 32'h10,0, 1));
    vecs.push_back(v(0, 0,0,0, 0,0,0, 1,1, 0,4,32'h22, 32'h0,1, 0));
    // write to r0: dropped with ZERO_REG_WE=0, performed with ZERO_REG_WE=1
    vecs.push_back(v(1, 0,0,0, 0,0,0, 0,0, 0,0,0, 32'h0,1, 0));
    vecs.push_back(v(0, 1,0,32'h55, 0,0,0, 1,1, 0,0,0, 32'h0,1, 0));
    vecs.push_back(v(0, 0,0,0, 0,0,0, 1,1, 0,0,0, 32'h0,0, 0));
    vecs.push_back(v(0, 0,0,0, 0,0,0, 1,1, 0,0,32'h55, 32'h0,1, 1));
    vecs.push_back(v(0, 0,0,0, 0,0,0, 1,1, 0,0,32'h55, 32'h0,1, 0));
    // both sources to r7: 0x1 then 0x2, pending[7] held throughout
    vecs.push_back(v(1, 0,0,0, 0,0,0, 0,0, 0,0,0, 32'h0,1, 0));
    vecs.push_back(v(0, 1,7,32'h1, 1,7,32'h2, 1,1, 0,0,0, 32'h0,1, 0));
    vecs.push_back(v(0, 0,0,0, 0,0,0, 1,0, 0,0,0, 32'h80,0, 0));
    vecs.push_back(v(0, 0,0,0, 0,0,0, 1,1, 1,7,32'h1, 32'h80,0, 1));
    vecs.push_back(v(0, 0,0,0, 0,0,0, 1,1, 1,7,32'h2, 32'h80,0, 1));
    vecs.push_back(v(0, 0,0,0, 0,0,0, 1,1, 0,7,32'h2, 32'h0,1, 0));
    // reset asserted mid-cycle with holdA valid and wr_en high
    vecs.push_back(v(0, 1,9,32'h99, 0,0,0, 1,1, 0,7,32'h2, 32'h0,1, 0));
    vecs.push_back(v(0, 1,10,32'hAA, 0,0,0, 1,1, 0,7,32'h2, 32'h200,0, 0));
    vecs.push_back(v(1, 0,0,0, 0,0,0, 0,0, 0,0,0, 32'h0,1, 0));
    vecs.push_back(v(0, 0,0,0, 0,0,0, 1,1, 0,0,0, 32'h0,1, 0));
    vecs.push_back(v(0, 0,0,0, 0,0,0, 1,1, 0,0,0, 32'h0,1, 0));

    foreach (vecs[i]) begin
      row = i;
      @(negedge clk);
      rst          = vecs[i].rst;
      bus0.a_valid = vecs[i].av;
      bus0.a_addr  = vecs[i].aa;
      bus0.a_data  = vecs[i].ad;
      bus0.b_valid = vecs[i].bv;
      bus0.b_addr  = vecs[i].ba;
      bus0.b_data  = vecs[i].bd;
      #1;
      chk("a_ready", 32'(bus0.a_ready), 32'(vecs[i].ar));
      chk("b_ready", 32'(bus0.b_ready), 32'(vecs[i].br));
      chk("wr_en",   32'(bus0.wr_en),   32'(vecs[i].we));
      chk("wr_addr", 32'(bus0.wr_addr), 32'(vecs[i].wa));
      chk("wr_data", bus0.wr_data,      vecs[i].wd);
      chk("pending", bus0.pending,      vecs[i].pend);
      chk("idle",    32'(bus0.idle),    32'(vecs[i].idle));
      chk("z1_wr_en", 32'(bus1.wr_en),  32'(vecs[i].we1));
      if (vecs[i].we1) chk("z1_wr_addr", 32'(bus1.wr_addr), 32'(vecs[i].wa));
    end

    // Both sources stream for 8 cycles; writes must alternate A,B,A,...
    // back to back with no loss or duplication (A accepts 5, B accepts 4).
    row = -1;
    ia = 0; ib = 0; nwr = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus0.wr_en) begin
        if (nwr % 2 == 0) begin
          ea = WA'(10 + nwr / 2); ed = 32'hA000_0000 + WD'(nwr / 2);
        end else begin
          ea = WA'(20 + nwr / 2); ed = 32'hB000_0000 + WD'(nwr / 2);
        end
        chk("stream_addr", 32'(bus0.wr_addr), 32'(ea));
        chk("stream_data", bus0.wr_data, ed);
        if (first_c < 0) first_c = c;
        last_c = c;
        nwr++;
      end
      if (c < 8) begin
        bus0.a_valid = 1'b1; bus0.a_addr = WA'(10 + ia); bus0.a_data = 32'hA000_0000 + WD'(ia);
        bus0.b_valid = 1'b1; bus0.b_addr = WA'(20 + ib); bus0.b_data = 32'hB000_0000 + WD'(ib);
      end else begin
        idle_inputs();
      end
      #1;
      hs_a = bus0.a_valid && bus0.a_ready;
      hs_b = bus0.b_valid && bus0.b_ready;
      @(posedge clk);
      if (hs_a) ia++;
      if (hs_b) ib++;
    end
    chk("stream_count", 32'(nwr), 32'd9);
    chk("stream_span",  32'(last_c - first_c), 32'd8);
    chk("stream_first", 32'(first_c), 32'd2);
    @(negedge clk);
    chk("stream_idle", 32'(bus0.idle), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
